// File: rtl/trig_sync_controller_if.sv
// Slow-control / synchronizer signal bundle for trig_sync_controller.
// Stats outputs exist only when TRIG_SYNC_LOCK_STATS_EN is defined.
interface trig_sync_controller_if;
  logic        enable;
  logic [11:0] matchedCount;
  logic [11:0] syncBCID;
  logic        syncReset_n;
  logic        locked;
  logic [11:0] lockedBCID;
  logic        fail;
  logic        lockLost;
  logic [3:0]  retryCnt;
  logic [2:0]  state;
`ifdef TRIG_SYNC_LOCK_STATS_EN
  logic [15:0] lossCount;
  logic [15:0] lockTime;
`endif

  modport master (
    output enable, matchedCount, syncBCID,
    input  syncReset_n, locked, lockedBCID, fail, lockLost, retryCnt, state
`ifdef TRIG_SYNC_LOCK_STATS_EN
    , input lossCount, lockTime
`endif
  );

  modport slave (
    input  enable, matchedCount, syncBCID,
    output syncReset_n, locked, lockedBCID, fail, lockLost, retryCnt, state
`ifdef TRIG_SYNC_LOCK_STATS_EN
    , output lossCount, lockTime
`endif
  );
endinterface

// File: rtl/trig_sync_controller.sv
// Sequences the trigger synchronizer: reset, search for a unique BCID, lock, retry and re-acquire.
// Optional lock statistics (lossCount, lockTime) enabled by TRIG_SYNC_LOCK_STATS_EN.
module trig_sync_controller #(
  parameter int unsigned ORBIT_LEN      = 3564,
  parameter int unsigned RESTART_CYCLES = 2,
  parameter int unsigned STABLE_ORBITS  = 2,
  parameter int unsigned MAX_ORBITS     = 64,
  parameter int unsigned MAX_RETRY      = 4,
  parameter int unsigned LOSS_THRESH    = 3
) (
  input logic                    clk40,
  input logic                    reset,
  trig_sync_controller_if.slave  bus
);

  localparam int unsigned RC_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       orbit_cnt_q, orbit_cnt_d;
  logic [7:0]        search_orbits_q, search_orbits_d;
  logic [3:0]        stable_cnt_q, stable_cnt_d;
  logic [3:0]        loss_cnt_q, loss_cnt_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic [RC_W-1:0]   restart_cnt_q, restart_cnt_d;
  logic              sync_reset_n_q, sync_reset_n_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              lock_lost_q, lock_lost_d;
  logic [11:0]       locked_bcid_q, locked_bcid_d;

  logic              tick, good;
  logic [11:0]       orbit_nxt;
  logic [7:0]        orbits_nxt;
  logic [3:0]        stable_nxt, loss_nxt, retry_nxt;

  // tick marks the last cycle of each orbit; counter updates are evaluated only there
  assign tick       = (orbit_cnt_q == 12'(ORBIT_LEN - 1));
  assign good       = (bus.matchedCount == 12'd1);
  assign orbit_nxt  = tick ? 12'd0 : orbit_cnt_q + 12'd1;
  assign orbits_nxt = search_orbits_q + 8'd1;
  assign stable_nxt = good ? stable_cnt_q + 4'd1 : 4'd0;
  assign loss_nxt   = good ? 4'd0 : loss_cnt_q + 4'd1;
  assign retry_nxt  = retry_cnt_q + 4'd1;

`ifdef TRIG_SYNC_LOCK_STATS_EN
  logic [15:0] acq_ticks_q, acq_ticks_d;
  logic [15:0] loss_count_q, loss_count_d;
  logic [15:0] lock_time_q, lock_time_d;
  logic [15:0] acq_inc;
  assign acq_inc = (acq_ticks_q == 16'hFFFF) ? acq_ticks_q : acq_ticks_q + 16'd1;
`endif

  always_ff @(posedge clk40) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      orbit_cnt_q     <= '0;
      search_orbits_q <= '0;
      stable_cnt_q    <= '0;
      loss_cnt_q      <= '0;
      retry_cnt_q     <= '0;
      restart_cnt_q   <= '0;
      sync_reset_n_q  <= 1'b0;
      locked_q        <= 1'b0;
      fail_q          <= 1'b0;
      lock_lost_q     <= 1'b0;
      locked_bcid_q   <= '0;
`ifdef TRIG_SYNC_LOCK_STATS_EN
      acq_ticks_q     <= '0;
      loss_count_q    <= '0;
      lock_time_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      orbit_cnt_q     <= orbit_cnt_d;
      search_orbits_q <= search_orbits_d;
      stable_cnt_q    <= stable_cnt_d;
      loss_cnt_q      <= loss_cnt_d;
      retry_cnt_q     <= retry_cnt_d;
      restart_cnt_q   <= restart_cnt_d;
      sync_reset_n_q  <= sync_reset_n_d;
      locked_q        <= locked_d;
      fail_q          <= fail_d;
      lock_lost_q     <= lock_lost_d;
      locked_bcid_q   <= locked_bcid_d;
`ifdef TRIG_SYNC_LOCK_STATS_EN
      acq_ticks_q     <= acq_ticks_d;
      loss_count_q    <= loss_count_d;
      lock_time_q     <= lock_time_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    orbit_cnt_d     = orbit_cnt_q;
    search_orbits_d = search_orbits_q;
    stable_cnt_d    = stable_cnt_q;
    loss_cnt_d      = loss_cnt_q;
    retry_cnt_d     = retry_cnt_q;
    restart_cnt_d   = restart_cnt_q;
    lock_lost_d     = lock_lost_q;
    locked_bcid_d   = locked_bcid_q;

    unique case (state_q)
      ST_IDLE: begin
        lock_lost_d = 1'b0;
        retry_cnt_d = 4'd0;
        state_d     = ST_RESTART;
      end
      ST_RESTART: begin
        if (restart_cnt_q == RC_W'(RESTART_CYCLES - 1)) state_d = ST_SEARCH;
        else restart_cnt_d = restart_cnt_q + RC_W'(1);
      end
      ST_SEARCH: begin
        orbit_cnt_d = orbit_nxt;
        if (tick) begin
          stable_cnt_d    = stable_nxt;
          search_orbits_d = orbits_nxt;
          // lock takes priority over a timeout landing on the same tick
          if (stable_nxt == 4'(STABLE_ORBITS)) begin
            state_d    = ST_LOCKED;
            loss_cnt_d = 4'd0;
          end else if (orbits_nxt == 8'(MAX_ORBITS)) begin
            retry_cnt_d = retry_nxt;
            state_d     = (retry_nxt == 4'(MAX_RETRY)) ? ST_FAIL : ST_RESTART;
          end
        end
      end
      ST_LOCKED: begin
        orbit_cnt_d = orbit_nxt;
        if (tick) begin
          loss_cnt_d = loss_nxt;
          if (loss_nxt == 4'(LOSS_THRESH)) begin
            state_d     = ST_RESTART;
            lock_lost_d = 1'b1;
            retry_cnt_d = 4'd0;
          end
        end
      end
      default: ;
    endcase

    if (!bus.enable) begin
      state_d     = ST_IDLE;
      retry_cnt_d = 4'd0;
      lock_lost_d = 1'b0;
    end

    // every path into RESTART starts a fresh search window
    if (state_d == ST_RESTART && state_q != ST_RESTART) begin
      restart_cnt_d   = '0;
      orbit_cnt_d     = '0;
      search_orbits_d = '0;
      stable_cnt_d    = '0;
    end

    if (state_q == ST_SEARCH && state_d == ST_LOCKED) locked_bcid_d = bus.syncBCID;

    sync_reset_n_d = (state_d == ST_SEARCH) || (state_d == ST_LOCKED);
    locked_d       = (state_d == ST_LOCKED);
    fail_d         = (state_d == ST_FAIL);
  end

`ifdef TRIG_SYNC_LOCK_STATS_EN
  // acquisition time spans all ticks since leaving IDLE, across retries and re-acquires
  always_comb begin
    acq_ticks_d  = acq_ticks_q;
    loss_count_d = loss_count_q;
    lock_time_d  = lock_time_q;
    if (state_q == ST_IDLE) acq_ticks_d = '0;
    else if (tick && (state_q == ST_SEARCH || state_q == ST_LOCKED)) acq_ticks_d = acq_inc;
    if (state_q == ST_SEARCH && state_d == ST_LOCKED) lock_time_d = acq_inc;
    if (state_q == ST_LOCKED && state_d == ST_RESTART && loss_count_q != 16'hFFFF)
      loss_count_d = loss_count_q + 16'd1;
  end

  assign bus.lossCount = loss_count_q;
  assign bus.lockTime  = lock_time_q;
`endif

  assign bus.state       = state_q;
  assign bus.syncReset_n = sync_reset_n_q;
  assign bus.locked      = locked_q;
  assign bus.lockedBCID  = locked_bcid_q;
  assign bus.fail        = fail_q;
  assign bus.lockLost    = lock_lost_q;
  assign bus.retryCnt    = retry_cnt_q;

endmodule

// File: tb/tb_trig_sync_controller.sv
// Bench for trig_sync_controller: directed scenarios against a cycle-level behavioural model.
// Short orbit (ORBIT_LEN=100) keeps the run small; stats checked when TRIG_SYNC_LOCK_STATS_EN is defined.
module tb_trig_sync_controller;

  localparam int ORBIT_LEN      = 100;
  localparam int RESTART_CYCLES = 2;
  localparam int STABLE_ORBITS  = 2;
  localparam int MAX_ORBITS     = 4;
  localparam int MAX_RETRY      = 3;
  localparam int LOSS_THRESH    = 3;

  localparam int S_IDLE = 0, S_RESTART = 1, S_SEARCH = 2, S_LOCKED = 3, S_FAIL = 4;

  logic clk40;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  trig_sync_controller_if tsc ();

  trig_sync_controller #(
    .ORBIT_LEN(ORBIT_LEN), .RESTART_CYCLES(RESTART_CYCLES), .STABLE_ORBITS(STABLE_ORBITS),
    .MAX_ORBITS(MAX_ORBITS), .MAX_RETRY(MAX_RETRY), .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk40(clk40),
    .reset(reset),
    .bus(tsc.slave)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since SEARCH entry in cycles, ticks where that lands on an orbit end.
  int m_st = S_IDLE, m_cyc = 0, m_rleft = 0, m_good = 0, m_orbits = 0, m_bad = 0;
  int m_retries = 0, m_lost = 0, m_bcid = 0, m_acq = 0, m_loss_count = 0, m_lock_time = 0;
  bit m_live = 0, m_tk;

  always @(posedge clk40) begin
    m_live = 1;
    if (!reset) begin
      m_st = S_IDLE; m_cyc = 0; m_rleft = 0; m_good = 0; m_orbits = 0; m_bad = 0;
      m_retries = 0; m_lost = 0; m_bcid = 0; m_acq = 0; m_loss_count = 0; m_lock_time = 0;
    end else if (!tsc.enable) begin
      m_st = S_IDLE; m_retries = 0; m_lost = 0; m_acq = 0;
    end else begin
      m_tk = (m_cyc % ORBIT_LEN) == ORBIT_LEN - 1;
      case (m_st)
        S_IDLE: begin
          m_acq = 0; m_st = S_RESTART; m_rleft = RESTART_CYCLES;
        end
        S_RESTART: begin
          m_rleft--;
          if (m_rleft == 0) begin
            m_st = S_SEARCH; m_cyc = 0; m_good = 0; m_orbits = 0;
          end
        end
        S_SEARCH: begin
          m_cyc++;
          if (m_tk) begin
            if (m_acq < 65535) m_acq++;
            m_orbits++;
            m_good = (tsc.matchedCount == 12'd1) ? m_good + 1 : 0;
            if (m_good == STABLE_ORBITS) begin
              m_st = S_LOCKED; m_bcid = int'(tsc.syncBCID); m_bad = 0; m_lock_time = m_acq;
            end else if (m_orbits == MAX_ORBITS) begin
              m_retries++;
              if (m_retries == MAX_RETRY) m_st = S_FAIL;
              else begin m_st = S_RESTART; m_rleft = RESTART_CYCLES; end
            end
          end
        end
        S_LOCKED: begin
          m_cyc++;
          if (m_tk) begin
            if (m_acq < 65535) m_acq++;
            m_bad = (tsc.matchedCount == 12'd1) ? 0 : m_bad + 1;
            if (m_bad == LOSS_THRESH) begin
              m_st = S_RESTART; m_rleft = RESTART_CYCLES; m_lost = 1; m_retries = 0;
              if (m_loss_count < 65535) m_loss_count++;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, plus RESTART entry counting.
  int restarts = 0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk40) begin
    if (m_live) begin
      chk("state", 16'(tsc.state), 16'(m_st));
      chk("syncReset_n", 16'(tsc.syncReset_n), 16'(m_st == S_SEARCH || m_st == S_LOCKED));
      chk("locked", 16'(tsc.locked), 16'(m_st == S_LOCKED));
      chk("fail", 16'(tsc.fail), 16'(m_st == S_FAIL));
      chk("lockLost", 16'(tsc.lockLost), 16'(m_lost));
      chk("retryCnt", 16'(tsc.retryCnt), 16'(m_retries));
      chk("lockedBCID", 16'(tsc.lockedBCID), 16'(m_bcid));
`ifdef TRIG_SYNC_LOCK_STATS_EN
      chk("lossCount", tsc.lossCount, 16'(m_loss_count));
      chk("lockTime", tsc.lockTime, 16'(m_lock_time));
`endif
      if (tsc.state == 3'd1 && prev_state != 3'd1) restarts++;
      prev_state = tsc.state;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk40);
    #3;
  endtask

  initial begin
    reset = 1'b0;
    tsc.enable = 1'b0;
    tsc.matchedCount = 12'd0;
    tsc.syncBCID = 12'd0;
    cyc(3);
    chk("rst_state", 16'(tsc.state), 16'd0);
    chk("rst_syncReset_n", 16'(tsc.syncReset_n), 16'd0);
    chk("rst_lockedBCID", 16'(tsc.lockedBCID), 16'd0);
    chk("rst_retryCnt", 16'(tsc.retryCnt), 16'd0);
    reset = 1'b1;
    cyc(2);

    // Constant single candidate: lock two orbits after SEARCH entry
    tsc.matchedCount = 12'd1; tsc.syncBCID = 12'h123; tsc.enable = 1'b1;
    cyc(1);
    chk("t1_restart", 16'(tsc.state), 16'd1);
    chk("t1_restart_srn", 16'(tsc.syncReset_n), 16'd0);
    cyc(2);
    chk("t1_search", 16'(tsc.state), 16'd2);
    chk("t1_search_srn", 16'(tsc.syncReset_n), 16'd1);
    cyc(199);
    chk("t1_prelock", 16'(tsc.locked), 16'd0);
    cyc(1);
    chk("t1_locked", 16'(tsc.locked), 16'd1);
    chk("t1_bcid", 16'(tsc.lockedBCID), 16'h123);
`ifdef TRIG_SYNC_LOCK_STATS_EN
    chk("t1_lockTime", tsc.lockTime, 16'd2);
`endif

    // Three bad ticks in LOCKED: re-acquire with lockLost set
    tsc.matchedCount = 12'd3564;
    cyc(299);
    chk("t3_still_locked", 16'(tsc.state), 16'd3);
    cyc(1);
    chk("t3_restart", 16'(tsc.state), 16'd1);
    chk("t3_lockLost", 16'(tsc.lockLost), 16'd1);
    chk("t3_unlocked", 16'(tsc.locked), 16'd0);
`ifdef TRIG_SYNC_LOCK_STATS_EN
    chk("t3_lossCount", tsc.lossCount, 16'd1);
`endif
    tsc.matchedCount = 12'd1; tsc.syncBCID = 12'h456;
    cyc(202);
    chk("t3_relock", 16'(tsc.state), 16'd3);
    chk("t3_relock_bcid", 16'(tsc.lockedBCID), 16'h456);
    chk("t3_lockLost_sticky", 16'(tsc.lockLost), 16'd1);

    // Two bad ticks then a good one: lock holds; off-tick transients ignored
    tsc.matchedCount = 12'd5;
    cyc(200);
    tsc.matchedCount = 12'd1;
    cyc(100);
    chk("t3_two_bad_hold", 16'(tsc.state), 16'd3);
    cyc(150);
    tsc.matchedCount = 12'd7;
    cyc(50);
    tsc.matchedCount = 12'd1;
    cyc(60);
    chk("t3_transient_hold", 16'(tsc.state), 16'd3);

    // Enable low mid-LOCKED
    tsc.enable = 1'b0;
    cyc(1);
    chk("t5_idle", 16'(tsc.state), 16'd0);
    chk("t5_lockLost_clr", 16'(tsc.lockLost), 16'd0);
    chk("t5_bcid_hold", 16'(tsc.lockedBCID), 16'h456);

    // No unique candidate: three attempts then FAIL
    tsc.matchedCount = 12'd5; tsc.enable = 1'b1;
    restarts = 0;
    cyc(1);
    cyc(1205);
    chk("t2_last_search", 16'(tsc.state), 16'd2);
    chk("t2_retry2", 16'(tsc.retryCnt), 16'd2);
    cyc(1);
    chk("t2_fail", 16'(tsc.fail), 16'd1);
    chk("t2_retry3", 16'(tsc.retryCnt), 16'd3);
    chk("t2_restart_pulses", 16'(restarts), 16'd3);
    tsc.matchedCount = 12'd1;
    cyc(300);
    chk("t2_fail_sticky", 16'(tsc.state), 16'd4);
    tsc.enable = 1'b0;
    cyc(1);
    chk("t2_fail_exit", 16'(tsc.state), 16'd0);
    chk("t2_retry_clr", 16'(tsc.retryCnt), 16'd0);

    // Second attempt: lock lands on the same tick as the timeout
    tsc.matchedCount = 12'd5; tsc.syncBCID = 12'h2AB; tsc.enable = 1'b1;
    cyc(1);
    cyc(604);
    tsc.matchedCount = 12'd1;
    cyc(199);
    chk("t4_search", 16'(tsc.state), 16'd2);
    chk("t4_retry1", 16'(tsc.retryCnt), 16'd1);
    cyc(1);
    chk("t4_locked", 16'(tsc.state), 16'd3);
    chk("t4_retry_kept", 16'(tsc.retryCnt), 16'd1);
    chk("t4_bcid", 16'(tsc.lockedBCID), 16'h2AB);

    // Enable low mid-SEARCH, then reset mid-RESTART
    tsc.enable = 1'b0;
    cyc(1);
    tsc.matchedCount = 12'd5; tsc.enable = 1'b1;
    cyc(51);
    chk("t5_in_search", 16'(tsc.state), 16'd2);
    tsc.enable = 1'b0;
    cyc(1);
    chk("t5_search_idle", 16'(tsc.state), 16'd0);
    chk("t5_search_srn", 16'(tsc.syncReset_n), 16'd0);
    chk("t5_bcid_hold2", 16'(tsc.lockedBCID), 16'h2AB);
    tsc.enable = 1'b1;
    cyc(2);
    chk("t5_in_restart", 16'(tsc.state), 16'd1);
    reset = 1'b0;
    cyc(1);
    chk("t5_rst_idle", 16'(tsc.state), 16'd0);
    chk("t5_rst_srn", 16'(tsc.syncReset_n), 16'd0);
    chk("t5_rst_bcid", 16'(tsc.lockedBCID), 16'd0);
    reset = 1'b1; tsc.enable = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
